// File: rtl/hc138_ack.sv
// hc138_ack -- registered 3-to-8 acknowledge decoder for an hc148 interrupt path.
//
// The block samples the active-low code and group-select of an 8-input priority
// encoder. It drives one active-low acknowledge line back to the winning
// requester for HOLD_CYCLES clocks. It then waits until the request is released
// before it will acknowledge again.
//
// Build option: define HC138_SYNC_EN to put a 2-flop synchronizer on en_N,
// code_N and gs_N. The synchronizer flops reset to 1 (inactive), and the
// request-to-ack latency becomes 3 edges. With the macro undefined, the inputs
// feed the FSM directly.
//
// Parameters:
//   HOLD_CYCLES  cycles an acknowledge line is held low (1..255, default 4)
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   en_N     active-low enable; high forces the decoder idle / aborts an ack
//   code_N   active-low encoder code; requester index = ~code_N
//   gs_N     active-low group select; low = valid request present
//   ack_N    active-low one-hot acknowledge (registered)
//   busy     high while acknowledging or waiting for request release
//   ack_cnt  number of acknowledges issued, modulo 256
module hc138_ack #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_N,
    input  logic [2:0] code_N,
    input  logic       gs_N,
    output logic [7:0] ack_N,
    output logic       busy,
    output logic [7:0] ack_cnt
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Inputs as seen by the FSM (either direct or synchronized)
    logic       en_s;
    logic       gs_s;
    logic [2:0] code_s;

`ifdef HC138_SYNC_EN
    // Bit order: {en_N, gs_N, code_N}. Flops reset to all-ones so that the FSM
    // sees "disabled, no request" while the chain refills after reset.
    logic [4:0] meta_reg;
    logic [4:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= 5'h1F;
            sync_reg <= 5'h1F;
        end else begin
            meta_reg <= {en_N, gs_N, code_N};
            sync_reg <= meta_reg;
        end
    end

    assign en_s   = sync_reg[4];
    assign gs_s   = sync_reg[3];
    assign code_s = sync_reg[2:0];
`else
    assign en_s   = en_N;
    assign gs_s   = gs_N;
    assign code_s = code_N;
`endif

    // Active-low one-hot pattern for the requester currently on the code bus.
    // The requester index is ~code_s.
    logic [7:0] ack_pattern;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign ack_pattern[gi] = ((~code_s) != 3'(gi));
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [7:0] ack_reg, ack_next;
    logic [7:0] hold_reg, hold_next;
    logic [7:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ack_reg   <= 8'hFF;
            hold_reg  <= 8'h00;
            cnt_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            hold_reg  <= hold_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ack_next   = ack_reg;
        hold_next  = hold_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                ack_next = 8'hFF;
                if (!en_s && !gs_s) begin
                    ack_next   = ack_pattern;
                    hold_next  = HOLD_LOAD;
                    cnt_next   = cnt_reg + 8'd1;
                    state_next = ACK;
                end
            end
            ACK: begin
                // The acknowledge pattern stays frozen. An abort by en_N wins
                // over the hold counter expiring in the same cycle.
                if (en_s) begin
                    ack_next   = 8'hFF;
                    state_next = IDLE;
                end else if (hold_reg == 8'h00) begin
                    ack_next   = 8'hFF;
                    state_next = RELEASE;
                end else begin
                    hold_next = hold_reg - 8'd1;
                end
            end
            RELEASE: begin
                // Stay here while the same request is still held, so that it
                // is never acknowledged twice.
                ack_next = 8'hFF;
                if (gs_s || en_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next   = 8'hFF;
                state_next = IDLE;
            end
        endcase
    end

    assign ack_N   = ack_reg;
    assign busy    = (state_reg != IDLE);
    assign ack_cnt = cnt_reg;

endmodule

// File: tb/tb_hc138_ack.sv
// tb_hc138_ack -- self-checking bench for hc138_ack.
// It drives two instances (HOLD_CYCLES=4 and HOLD_CYCLES=1) from the same
// inputs. A behavioural model predicts every output after every edge. Directed
// scenarios add explicit constant checks, and a randomized phase follows them.
module tb_hc138_ack;

`ifdef HC138_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic [2:0] code_n;
    logic       gs_n;

    logic [7:0] ack0, ack1;
    logic       busy0, busy1;
    logic [7:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    hc138_ack #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_N(en_n), .code_N(code_n), .gs_N(gs_n),
        .ack_N(ack0), .busy(busy0), .ack_cnt(cnt0)
    );

    hc138_ack #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_N(en_n), .code_N(code_n), .gs_N(gs_n),
        .ack_N(ack1), .busy(busy1), .ack_cnt(cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural model, kept per instance.
    // rem = remaining cycles with ack low.
    // blk = waiting for the request to be released.
    int         hold_c [2] = '{4, 1};
    int         rem    [2];
    bit         blk    [2];
    int         who    [2];
    logic [7:0] mcnt   [2];
    logic [4:0] pipe1, pipe2;   // {en, gs, code} delay line for the synchronized build

    task automatic model_update();
        logic       e, g;
        logic [2:0] c;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                rem[i] = 0; blk[i] = 0; mcnt[i] = 8'h00; who[i] = 0;
            end
            pipe1 = 5'h1F;
            pipe2 = 5'h1F;
        end else begin
            if (LAT == 0) begin
                e = en_n; g = gs_n; c = code_n;
            end else begin
                {e, g, c} = pipe2;
                pipe2 = pipe1;
                pipe1 = {en_n, gs_n, code_n};
            end
            for (int i = 0; i < 2; i++) begin
                if (rem[i] > 0) begin
                    if (e) rem[i] = 0;
                    else begin
                        rem[i] = rem[i] - 1;
                        if (rem[i] == 0) blk[i] = 1;
                    end
                end else if (blk[i]) begin
                    if (g || e) blk[i] = 0;
                end else if (!e && !g) begin
                    rem[i]  = hold_c[i];
                    who[i]  = 7 - int'(c);
                    mcnt[i] = mcnt[i] + 8'd1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_ack(int i);
        logic [7:0] one;
        one = 8'd1;
        return (rem[i] > 0) ? ~(one << who[i]) : 8'hFF;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_update();
            #1;
            chk("ack0",    ack0,        exp_ack(0));
            chk("busy0",   8'(busy0),   8'(rem[0] > 0 || blk[0]));
            chk("cnt0",    cnt0,        mcnt[0]);
            chk("ack1",    ack1,        exp_ack(1));
            chk("busy1",   8'(busy1),   8'(rem[1] > 0 || blk[1]));
            chk("cnt1",    cnt1,        mcnt[1]);
            chk("onehot0", 8'($countones(~ack0) <= 1), 8'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en_n = 1'b1; code_n = 3'b111; gs_n = 1'b1;
        pipe1 = 5'h1F; pipe2 = 5'h1F;
        #2;
        step(2);
        chk("rst_ack", ack0, 8'hFF);
        chk("rst_busy", 8'(busy0), 8'h00);
        chk("rst_cnt", cnt0, 8'h00);
        $display("reset: ack_N=%h busy=%0d ack_cnt=%0d", ack0, busy0, cnt0);
        rst_n = 1'b1;
        step(2);

        // Requester 5 is acknowledged for 4 cycles, then held in RELEASE.
        code_n = 3'b010; gs_n = 1'b0; en_n = 1'b0;
        step(1 + LAT);
        chk("req5_ack", ack0, 8'b1101_1111);
        chk("req5_busy", 8'(busy0), 8'h01);
        chk("req5_cnt", cnt0, 8'h01);
        step(3);
        chk("req5_ack_last", ack0, 8'b1101_1111);
        step(1);
        chk("req5_ack_end", ack0, 8'hFF);
        step(20);
        chk("req5_held_busy", 8'(busy0), 8'h01);
        chk("req5_held_cnt", cnt0, 8'h01);
        $display("requester 5: acknowledged once, ack_cnt=%0d", cnt0);

        // Release for one cycle, then requester 0.
        gs_n = 1'b1;
        step(1);
        gs_n = 1'b0; code_n = 3'b111;
        step(1 + LAT);
        chk("req0_ack", ack0, 8'hFE);
        chk("req0_cnt", cnt0, 8'h02);
        step(8);
        chk("req0_single", cnt0, 8'h02);
        $display("requester 0: ack_cnt=%0d", cnt0);

        // Abort with en_N in the second ACK cycle.
        gs_n = 1'b1;
        step(3 + LAT);
        gs_n = 1'b0; code_n = 3'b100;
        step(1 + LAT);
        step(1);
        en_n = 1'b1;
        step(1 + LAT);
        chk("abort_ack", ack0, 8'hFF);
        chk("abort_busy", 8'(busy0), 8'h00);
        chk("abort_cnt", cnt0, 8'h03);
        $display("abort: ack_N=%h busy=%0d ack_cnt=%0d", ack0, busy0, cnt0);
        en_n = 1'b0; gs_n = 1'b1;
        step(2 + LAT);

        // Reset while an acknowledge is in progress.
        gs_n = 1'b0; code_n = 3'b001;
        step(1 + LAT);
        rst_n = 1'b0;
        step(1);
        chk("rstack_ack", ack0, 8'hFF);
        chk("rstack_busy", 8'(busy0), 8'h00);
        chk("rstack_cnt", cnt0, 8'h00);
        $display("reset during ack: ack_N=%h ack_cnt=%0d", ack0, cnt0);
        rst_n = 1'b1; gs_n = 1'b1;
        step(2 + LAT);

        // 256 request/release cycles sweeping all codes: the counter wraps.
        for (int r = 0; r < 256; r++) begin
            logic [7:0] one;
            logic [2:0] c;
            one = 8'd1;
            c = 3'(r);
            code_n = c; gs_n = 1'b0; en_n = 1'b0;
            step(1 + LAT);
            chk("sweep_ack", ack0, ~(one << (3'd7 - c)));
            chk("sweep_ack_h1", ack1, ~(one << (3'd7 - c)));
            $display("sweep %0d: code_N=%b ack_N=%h ack_N(h1)=%h", r, c, ack0, ack1);
            gs_n = 1'b1;
            step(6 + LAT);
        end
        chk("wrap_cnt0", cnt0, 8'h00);
        chk("wrap_cnt1", cnt1, 8'h00);

        // Randomized traffic checked against the model on every edge.
        for (int r = 0; r < 1500; r++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            en_n   = ($urandom_range(0, 9) == 0);
            gs_n   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) code_n = 3'($urandom);
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
